res_ttl_pulse_chk: RTL and testbench

Checker stage that sits directly upstream of the res_ttl counter stage and consumes the same res_ttl1_in line that stage receives.
- Measures every res_ttl pulse: high width in clk_100Mz cycles, and rising-to-rising period in 1 MHz ticks.
- Compares both against programmed windows and accumulates pass/error statistics for the check unit's result readout.
- Flags a missing-pulse timeout.

---
 rtl/res_ttl_pkg.sv | 19 +
 rtl/res_ttl_pulse_chk_if.sv | 33 +++
 rtl/res_ttl_edge_sync.sv | 70 +++++++
 rtl/res_ttl_pulse_chk.sv | 158 +++++++++++++++
 tb/tb_res_ttl_pulse_chk.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/res_ttl_pkg.sv
// Shared types and helpers for the res_ttl pulse checker.
package res_ttl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SYNC  = 3'd1,
        ARMED = 3'd2,
        HIGH  = 3'd3,
        LOW   = 3'd4
    } res_ttl_state_e;

    localparam int unsigned DEGLITCH_N = 4;

    // Increment that sticks at vmax instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] vmax);
        return (v >= vmax) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/res_ttl_pulse_chk_if.sv
// Configuration and result bus between the check unit and the pulse checker.
interface res_ttl_pulse_chk_if #(
    parameter int unsigned WIDTH_W  = 16,
    parameter int unsigned PERIOD_W = 16,
    parameter int unsigned STAT_W   = 16
);
    logic                enable;
    logic                clear;
    logic [WIDTH_W-1:0]  width_min;
    logic [WIDTH_W-1:0]  width_max;
    logic [PERIOD_W-1:0] period_min;
    logic [PERIOD_W-1:0] period_max;

    logic [WIDTH_W-1:0]  last_width;
    logic [PERIOD_W-1:0] last_period;
    logic                result_valid;
    logic [STAT_W-1:0]   pulse_cnt;
    logic [STAT_W-1:0]   err_width_cnt;
    logic [STAT_W-1:0]   err_period_cnt;
    logic                timeout;

    modport master (
        output enable, clear, width_min, width_max, period_min, period_max,
        input  last_width, last_period, result_valid, pulse_cnt,
               err_width_cnt, err_period_cnt, timeout
    );

    modport slave (
        input  enable, clear, width_min, width_max, period_min, period_max,
        output last_width, last_period, result_valid, pulse_cnt,
               err_width_cnt, err_period_cnt, timeout
    );
endinterface

// File: rtl/res_ttl_edge_sync.sv
// Two-flop synchroniser, optional stability filter, registered level and edge strobes.
module res_ttl_edge_sync
    import res_ttl_pkg::*;
#(
    parameter bit DEGLITCH = 1'b0
) (
    input  logic clk_100Mz,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic sync1;
    logic sync2;
    logic stage;

    always_ff @(posedge clk_100Mz) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
        end
    end

    generate
        if (DEGLITCH) begin : g_dgl
            localparam int unsigned CNT_W = $clog2(DEGLITCH_N);
            logic             filt;
            logic [CNT_W-1:0] cnt;

            // Filtered level flips only after DEGLITCH_N consecutive differing samples.
            always_ff @(posedge clk_100Mz) begin
                if (rst) begin
                    filt <= 1'b0;
                    cnt  <= '0;
                end else if (sync2 != filt) begin
                    if (cnt == CNT_W'(DEGLITCH_N - 1)) begin
                        filt <= sync2;
                        cnt  <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end else begin
                    cnt <= '0;
                end
            end

            assign stage = filt;
        end else begin : g_raw
            assign stage = sync2;
        end
    endgenerate

    always_ff @(posedge clk_100Mz) begin
        if (rst) begin
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            level <= stage;
            rise  <= stage & ~level;
            fall  <= ~stage & level;
        end
    end

endmodule

// File: rtl/res_ttl_pulse_chk.sv
// res_ttl pulse width/period checker with window statistics and missing-pulse timeout.
// Build option: RES_TTL_CHK_DEGLITCH_EN adds a stability filter on the res_ttl line.
module res_ttl_pulse_chk
    import res_ttl_pkg::*;
#(
    parameter int unsigned WIDTH_W    = 16,
    parameter int unsigned PERIOD_W   = 16,
    parameter int unsigned STAT_W     = 16,
    parameter int unsigned TIMEOUT_US = 1000
) (
    input  logic                clk_100Mz,
    input  logic                rst,
    input  logic                clk_1Mz,
    input  logic                res_ttl1_in,
    res_ttl_pulse_chk_if.slave  bus
);

`ifdef RES_TTL_CHK_DEGLITCH_EN
    localparam bit TTL_DEGLITCH = 1'b1;
`else
    localparam bit TTL_DEGLITCH = 1'b0;
`endif

    localparam int unsigned TMO_W = $clog2(TIMEOUT_US + 1);
    localparam logic [WIDTH_W-1:0]  W_MAX = '1;
    localparam logic [PERIOD_W-1:0] P_MAX = '1;
    localparam logic [STAT_W-1:0]   S_MAX = '1;

    logic ttl_lvl;
    logic ttl_rise;
    logic ttl_fall;
    logic tick;
    logic tick_lvl_unused;
    logic tick_fall_unused;

    res_ttl_edge_sync #(.DEGLITCH(TTL_DEGLITCH)) u_ttl_sync (
        .clk_100Mz (clk_100Mz),
        .rst       (rst),
        .din       (res_ttl1_in),
        .level     (ttl_lvl),
        .rise      (ttl_rise),
        .fall      (ttl_fall)
    );

    res_ttl_edge_sync #(.DEGLITCH(1'b0)) u_tick_sync (
        .clk_100Mz (clk_100Mz),
        .rst       (rst),
        .din       (clk_1Mz),
        .level     (tick_lvl_unused),
        .rise      (tick),
        .fall      (tick_fall_unused)
    );

    res_ttl_state_e state;
    res_ttl_state_e state_nxt;

    logic [WIDTH_W-1:0]  width_ctr;
    logic [PERIOD_W-1:0] period_ctr;
    logic [PERIOD_W-1:0] period_now;
    logic [TMO_W-1:0]    tmo_ctr;
    logic                running;
    logic                start;
    logic                meas_width;
    logic                meas_period;
    logic                width_bad;
    logic                period_bad;
    logic                tmo_hit;

    always_ff @(posedge clk_100Mz) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state; dropping enable forces IDLE from anywhere.
    always_comb begin
        state_nxt = state;
        if (!bus.enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = SYNC;
                SYNC:    if (!ttl_lvl)  state_nxt = ARMED;
                ARMED:   if (ttl_rise)  state_nxt = HIGH;
                HIGH:    if (ttl_fall)  state_nxt = LOW;
                LOW:     if (ttl_rise)  state_nxt = HIGH;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        running     = bus.enable && ((state == ARMED) || (state == HIGH) || (state == LOW));
        start       = running && (state != HIGH) && ttl_rise;
        meas_width  = bus.enable && (state == HIGH) && ttl_fall;
        meas_period = bus.enable && (state == LOW) && ttl_rise;
        // A tick coinciding with the closing rise still belongs to the period being closed.
        period_now  = tick ? PERIOD_W'(sat_inc(32'(period_ctr), 32'(P_MAX))) : period_ctr;
        width_bad   = (width_ctr < bus.width_min) || (width_ctr > bus.width_max);
        period_bad  = (period_now < bus.period_min) || (period_now > bus.period_max);
        tmo_hit     = running && !ttl_rise && tick && (tmo_ctr == TMO_W'(TIMEOUT_US - 1));
    end

    // Width, period and timeout measurement counters.
    always_ff @(posedge clk_100Mz) begin
        if (rst) begin
            width_ctr  <= '0;
            period_ctr <= '0;
            tmo_ctr    <= '0;
        end else begin
            if (start)
                width_ctr <= WIDTH_W'(1);
            else if (running && (state == HIGH))
                width_ctr <= WIDTH_W'(sat_inc(32'(width_ctr), 32'(W_MAX)));
            else if (!running)
                width_ctr <= '0;

            if (running && (state != ARMED) && !start)
                period_ctr <= period_now;
            else
                period_ctr <= '0;

            if (!running || bus.clear || ttl_rise)
                tmo_ctr <= '0;
            else if (tick && (tmo_ctr != TMO_W'(TIMEOUT_US)))
                tmo_ctr <= tmo_ctr + TMO_W'(1);
        end
    end

    // Results and statistics; clear takes priority over any update in the same cycle.
    always_ff @(posedge clk_100Mz) begin
        if (rst || bus.clear) begin
            bus.last_width     <= '0;
            bus.last_period    <= '0;
            bus.result_valid   <= 1'b0;
            bus.pulse_cnt      <= '0;
            bus.err_width_cnt  <= '0;
            bus.err_period_cnt <= '0;
            bus.timeout        <= 1'b0;
        end else begin
            bus.result_valid <= 1'b0;
            if (meas_width) begin
                bus.last_width   <= width_ctr;
                bus.result_valid <= 1'b1;
                bus.pulse_cnt    <= STAT_W'(sat_inc(32'(bus.pulse_cnt), 32'(S_MAX)));
                if (width_bad)
                    bus.err_width_cnt <= STAT_W'(sat_inc(32'(bus.err_width_cnt), 32'(S_MAX)));
            end
            if (meas_period) begin
                bus.last_period <= period_now;
                if (period_bad)
                    bus.err_period_cnt <= STAT_W'(sat_inc(32'(bus.err_period_cnt), 32'(S_MAX)));
            end
            if (tmo_hit)
                bus.timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_res_ttl_pulse_chk.sv
// Scoreboard bench for res_ttl_pulse_chk: directed pulses, expected results queued and checked on result_valid.
module tb_res_ttl_pulse_chk;
    import res_ttl_pkg::*;

`ifdef RES_TTL_CHK_DEGLITCH_EN
    localparam int LAT = 7;
`else
    localparam int LAT = 3;
`endif
    localparam int TMO = 20;

    typedef struct {
        int w;
        int lp;
        int pc;
        int ew;
        int ep;
    } exp_t;

    logic clk_100Mz;
    logic rst;
    logic clk_1Mz;
    logic res_ttl1_in;

    res_ttl_pulse_chk_if #(.WIDTH_W(16), .PERIOD_W(16), .STAT_W(16)) bus ();

    res_ttl_pulse_chk #(
        .WIDTH_W(16), .PERIOD_W(16), .STAT_W(16), .TIMEOUT_US(TMO)
    ) dut (
        .clk_100Mz   (clk_100Mz),
        .rst         (rst),
        .clk_1Mz     (clk_1Mz),
        .res_ttl1_in (res_ttl1_in),
        .bus         (bus)
    );

    exp_t sb[$];
    int   n_vec;
    int   n_err;
    int   n_strobe;
    int   n_push;

    // Reference model state
    int m_pc, m_ew, m_ep, m_lp, m_prev;
    bit m_first;
    int wmin, wmax, pmin, pmax;

    initial begin
        clk_100Mz = 1'b0;
        forever #5 clk_100Mz = ~clk_100Mz;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_100Mz);
    endtask

    initial begin
        clk_1Mz = 1'b0;
        forever begin
            cyc(50);
            clk_1Mz = ~clk_1Mz;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every result_valid strobe pops one expected result.
    always @(posedge clk_100Mz) begin
        #1;
        if (bus.result_valid === 1'b1) begin
            exp_t e;
            n_strobe++;
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_unexpected: result_valid with width %0d, expected no strobe", bus.last_width);
            end else begin
                e = sb.pop_front();
                chk("res_last_width",  32'(bus.last_width),     32'(e.w));
                chk("res_last_period", 32'(bus.last_period),    32'(e.lp));
                chk("res_pulse_cnt",   32'(bus.pulse_cnt),      32'(e.pc));
                chk("res_err_width",   32'(bus.err_width_cnt),  32'(e.ew));
                chk("res_err_period",  32'(bus.err_period_cnt), 32'(e.ep));
            end
        end
    end

    task automatic model_clear();
        m_pc = 0; m_ew = 0; m_ep = 0; m_lp = 0;
    endtask

    // Drive one pulse (per cycles rise-to-rise) and queue its expected result.
    task automatic do_pulse(input int hi, input int per);
        exp_t e;
        if (!m_first) begin
            m_lp = m_prev;
            if (m_lp < pmin || m_lp > pmax) m_ep++;
        end
        m_first = 1'b0;
        m_pc++;
        if (hi < wmin || hi > wmax) m_ew++;
        m_prev = per / 100;
        e.w = hi; e.lp = m_lp; e.pc = m_pc; e.ew = m_ew; e.ep = m_ep;
        sb.push_back(e);
        n_push++;
        res_ttl1_in = 1'b1;
        cyc(hi);
        res_ttl1_in = 1'b0;
        cyc(per - hi);
    endtask

    task automatic set_windows(input int a, input int b, input int c, input int d);
        wmin = a; wmax = b; pmin = c; pmax = d;
        bus.width_min  = 16'(a);
        bus.width_max  = 16'(b);
        bus.period_min = 16'(c);
        bus.period_max = 16'(d);
    endtask

    initial begin
        n_vec = 0; n_err = 0; n_strobe = 0; n_push = 0;
        m_first = 1'b1; m_prev = 0;
        model_clear();
        rst = 1'b1;
        res_ttl1_in = 1'b0;
        bus.enable = 1'b0;
        bus.clear  = 1'b0;
        set_windows(45, 55, 9, 11);
        cyc(5);

        chk("rst_last_width",   32'(bus.last_width),     0);
        chk("rst_last_period",  32'(bus.last_period),    0);
        chk("rst_pulse_cnt",    32'(bus.pulse_cnt),      0);
        chk("rst_err_width",    32'(bus.err_width_cnt),  0);
        chk("rst_err_period",   32'(bus.err_period_cnt), 0);
        chk("rst_timeout",      32'(bus.timeout),        0);
        chk("rst_result_valid", 32'(bus.result_valid),   0);

        rst = 1'b0;
        bus.enable = 1'b1;
        cyc(20);

        // Five clean pulses: 50 cycles high, 10 us period
        for (int i = 0; i < 5; i++) do_pulse(50, 1000);
        chk("t1_pulse_cnt",   32'(bus.pulse_cnt),      5);
        chk("t1_err_width",   32'(bus.err_width_cnt),  0);
        chk("t1_err_period",  32'(bus.err_period_cnt), 0);
        chk("t1_last_width",  32'(bus.last_width),     50);
        chk("t1_last_period", 32'(bus.last_period),    10);

        // Width error plus inclusive window edges; 12 us period is a period error
        do_pulse(60, 1000);
        do_pulse(45, 1000);
        do_pulse(55, 1100);
        do_pulse(50, 1200);
        do_pulse(50, 1000);
        chk("t2_pulse_cnt",  32'(bus.pulse_cnt),      10);
        chk("t2_err_width",  32'(bus.err_width_cnt),  1);
        chk("t2_err_period", 32'(bus.err_period_cnt), 1);

        // Enable raised while the line is already high
        bus.enable = 1'b0;
        cyc(2);
        bus.clear = 1'b1;
        cyc(1);
        bus.clear = 1'b0;
        model_clear();
        m_first = 1'b1;
        chk("t3_clr_pulse_cnt",   32'(bus.pulse_cnt),   0);
        chk("t3_clr_last_period", 32'(bus.last_period), 0);
        res_ttl1_in = 1'b1;
        cyc(10);
        bus.enable = 1'b1;
        cyc(40);
        res_ttl1_in = 1'b0;
        cyc(500);
        do_pulse(50, 1000);
        chk("t3_pulse_cnt",   32'(bus.pulse_cnt),   1);
        chk("t3_last_period", 32'(bus.last_period), 0);

        // Missing pulse timeout, then clear coinciding with a fall
        cyc(500);
        chk("t4_timeout_early", 32'(bus.timeout), 0);
        cyc(1000);
        chk("t4_timeout_set", 32'(bus.timeout), 1);
        res_ttl1_in = 1'b1;
        cyc(50);
        res_ttl1_in = 1'b0;
        cyc(LAT);
        bus.clear = 1'b1;
        cyc(1);
        bus.clear = 1'b0;
        model_clear();
        m_prev = 10;
        chk("t4_clr_pulse_cnt",   32'(bus.pulse_cnt),      0);
        chk("t4_clr_last_width",  32'(bus.last_width),     0);
        chk("t4_clr_last_period", 32'(bus.last_period),    0);
        chk("t4_clr_err_period",  32'(bus.err_period_cnt), 0);
        chk("t4_clr_timeout",     32'(bus.timeout),        0);
        cyc(1000 - 50 - LAT - 1);
        do_pulse(50, 1000);
        chk("t4_pulse_cnt", 32'(bus.pulse_cnt), 1);

        // Reset in the middle of a high phase
        res_ttl1_in = 1'b1;
        cyc(20);
        rst = 1'b1;
        cyc(1);
        chk("t5_last_width",   32'(bus.last_width),   0);
        chk("t5_last_period",  32'(bus.last_period),  0);
        chk("t5_pulse_cnt",    32'(bus.pulse_cnt),    0);
        chk("t5_result_valid", 32'(bus.result_valid), 0);
        chk("t5_state",        32'(dut.state),        32'(IDLE));
        res_ttl1_in = 1'b0;
        cyc(1);
        rst = 1'b0;
        model_clear();
        m_first = 1'b1;
        cyc(20);

        // Two-cycle glitch
`ifdef RES_TTL_CHK_DEGLITCH_EN
        res_ttl1_in = 1'b1;
        cyc(2);
        res_ttl1_in = 1'b0;
        cyc(200);
        chk("t6_pulse_cnt",  32'(bus.pulse_cnt),  0);
        chk("t6_last_width", 32'(bus.last_width), 0);
`else
        do_pulse(2, 200);
        chk("t6_pulse_cnt",  32'(bus.pulse_cnt),  1);
        chk("t6_last_width", 32'(bus.last_width), 2);
`endif

        cyc(20);
        chk("sb_empty",     32'(sb.size()), 0);
        chk("strobe_count", 32'(n_strobe),  32'(n_push));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
